// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Decoupling FIFO between the fetch and decode stages. Fetch pushes
//   {inst_F, pc_plus4_F} pairs and decode pops them as {inst_D, pc_plus4_D}.
//   A decode stall therefore back-pressures fetch through in_ready instead of
//   freezing the PC register directly. A flush (taken branch / redirect)
//   discards every queued entry.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
//   in_ready  = !full  and out_valid = !empty. Both depend only on the
//   registered pointers, never on in_valid/out_ready, so no combinational
//   paths run from either handshake input to either handshake output.
//
// Ports:
//   clk          core clock, rising edge
//   reset        synchronous, active-low reset (beats flush, push and pop)
//   in_valid     fetch offers an entry
//   in_ready     queue can accept an entry (!full)
//   inst_F       instruction word from fetch
//   pc_plus4_F   PC+4 of that instruction
//   flush        discard all entries at the next edge; push/pop ignored
//   out_valid    head entry presented (!empty)
//   out_ready    decode consumes the head entry
//   inst_D       head instruction, 0 (NOP) while empty
//   pc_plus4_D   head PC+4, 0 while empty
//   count        current occupancy
//
// Optional build macro FETCH_QUEUE_STATS_EN adds:
//   stall_cycles     cycles with in_valid && !in_ready (saturating)
//   flushed_entries  entries discarded by flushes, including a push offered
//                    in the flush cycle (saturating)
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int N     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             inst_F,
  input  logic [N-1:0]             pc_plus4_F,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             inst_D,
  output logic [N-1:0]             pc_plus4_D,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [31:0]              flushed_entries
`endif
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [N-1:0]  r_mem_inst [DEPTH];
  logic [N-1:0]  r_mem_pc   [DEPTH];

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign count     = r_wr_ptr - r_rd_ptr;

  // Empty forces a NOP onto the decode side so stale storage never leaks.
  assign inst_D     = w_empty ? '0 : r_mem_inst[w_rd_idx];
  assign pc_plus4_D = w_empty ? '0 : r_mem_pc[w_rd_idx];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; contents are masked by empty after reset/flush.
  always_ff @(posedge clk) begin
    if (reset && !flush && w_push) begin
      r_mem_inst[w_wr_idx] <= inst_F;
      r_mem_pc[w_wr_idx]   <= pc_plus4_F;
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [32:0] w_flush_sum;

  // Widened sum so saturation can be detected from the carry bit.
  assign w_flush_sum = {1'b0, flushed_entries}
                     + {{(33-AW-1){1'b0}}, count}
                     + {32'd0, in_valid};

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles    <= '0;
      flushed_entries <= '0;
    end else begin
      if (in_valid && !in_ready && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (flush)
        flushed_entries <= w_flush_sum[32] ? 32'hFFFF_FFFF : w_flush_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Directed scenarios followed by randomized traffic, checked every cycle
//   against a queue-based reference of the fetch/decode buffer.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int N     = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset      = 1'b0;
  logic           in_valid   = 1'b0;
  logic           in_ready;
  logic [N-1:0]   inst_F     = '0;
  logic [N-1:0]   pc_plus4_F = '0;
  logic           flush      = 1'b0;
  logic           out_valid;
  logic           out_ready  = 1'b0;
  logic [N-1:0]   inst_D;
  logic [N-1:0]   pc_plus4_D;
  logic [CW-1:0]  count;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0]    stall_cycles;
  logic [31:0]    flushed_entries;
`endif

  fetch_queue #(.DEPTH(DEPTH), .N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inst_F     (inst_F),
    .pc_plus4_F (pc_plus4_F),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .inst_D     (inst_D),
    .pc_plus4_D (pc_plus4_D),
    .count      (count)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .stall_cycles    (stall_cycles),
    .flushed_entries (flushed_entries)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [2*N-1:0] exp_q[$];   // {inst, pc_plus4}, head at index 0
  longint         exp_stall   = 0;
  longint         exp_flushed = 0;
  int             n_vec = 0;
  int             n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] e_inst;
    logic [N-1:0] e_pc;
    e_inst = '0;
    e_pc   = '0;
    if (exp_q.size() > 0) begin
      e_inst = exp_q[0][2*N-1:N];
      e_pc   = exp_q[0][N-1:0];
    end
    check("count",      64'(count),      64'(exp_q.size()));
    check("out_valid",  64'(out_valid),  64'(exp_q.size() > 0));
    check("in_ready",   64'(in_ready),   64'(exp_q.size() < DEPTH));
    check("inst_D",     64'(inst_D),     64'(e_inst));
    check("pc_plus4_D", 64'(pc_plus4_D), 64'(e_pc));
`ifdef FETCH_QUEUE_STATS_EN
    check("stall_cycles",    64'(stall_cycles),    64'(exp_stall));
    check("flushed_entries", 64'(flushed_entries), 64'(exp_flushed));
`endif
  endtask

  // Reference: occupancy limits decide acceptance, head-of-queue is output.
  task automatic model_edge(input logic rst_n, input logic iv, input logic fl,
                            input logic ordy, input logic [N-1:0] inst,
                            input logic [N-1:0] pc);
    int  sz;
    bit  do_pop;
    bit  do_push;
    sz = exp_q.size();
    if (!rst_n) begin
      exp_q.delete();
      exp_stall   = 0;
      exp_flushed = 0;
    end else begin
      if (iv && sz == DEPTH && exp_stall < 64'hFFFF_FFFF) exp_stall++;
      if (fl) begin
        exp_flushed = exp_flushed + sz + (iv ? 1 : 0);
        if (exp_flushed > 64'hFFFF_FFFF) exp_flushed = 64'hFFFF_FFFF;
        exp_q.delete();
      end else begin
        do_pop  = ordy && (sz > 0);
        do_push = iv && (sz < DEPTH);
        if (do_pop)  void'(exp_q.pop_front());
        if (do_push) exp_q.push_back({inst, pc});
      end
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after an edge; outputs are checked there too.
  task automatic cyc(input logic rst_n, input logic iv, input logic fl,
                     input logic ordy, input logic [N-1:0] inst,
                     input logic [N-1:0] pc);
    reset      = rst_n;
    in_valid   = iv;
    flush      = fl;
    out_ready  = ordy;
    inst_F     = inst;
    pc_plus4_F = pc;
    @(posedge clk);
    model_edge(rst_n, iv, fl, ordy, inst, pc);
    #1;
    check_all();
  endtask

  logic [N-1:0] fill_words [4];
  int           leak_seen;

  initial begin
    fill_words[0] = 32'h0000_0013;
    fill_words[1] = 32'h0040_0093;
    fill_words[2] = 32'h0080_0113;
    fill_words[3] = 32'h00C0_0193;

    #1;
    // Reset held two cycles with in_valid asserted, then idle.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'hAAAA_AAAA, 32'h4);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'hBBBB_BBBB, 32'h8);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("reset_idle_count", 64'(count), 64'd0);

    // Fill, then a rejected 5th offer, then drain in order.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b1, 1'b0, 1'b0, fill_words[i], 32'(4 * (i + 1)));
    check("fill_count", 64'(count), 64'd4);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h14);
    for (int i = 0; i < 4; i++) begin
      check("drain_head", 64'(inst_D), 64'(fill_words[i]));
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    end
    check("drain_empty", 64'(out_valid), 64'd0);

    // Concurrent push/pop at occupancy 2; pointers wrap more than twice.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h1004);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h101, 32'h1008);
    for (int i = 0; i < 10; i++) begin
      check("conc_head", 64'(inst_D), 64'(32'h100 + i));
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'(32'h102 + i), 32'(32'h100C + 4 * i));
      check("conc_count", 64'(count), 64'd2);
    end

    // Full plus pop: only the pop happens, the slot frees next cycle.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h2004);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h201, 32'h2008);
    check("full_count", 64'(count), 64'd4);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h202, 32'h200C);
    check("full_pop_count", 64'(count), 64'd3);
    check("full_pop_ready", 64'(in_ready), 64'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h203, 32'h2010);
    check("refill_count", 64'(count), 64'd4);

    // Hold full with in_valid for 7 cycles (stall counter when built in).
    for (int i = 0; i < 7; i++)
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h300 + 32'(i), 32'h3000);

    // Drop to 3 entries, then flush alongside a push.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    check("pre_flush_count", 64'(count), 64'd3);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 32'h4444);
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    leak_seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'(i < 3), 1'b0, 1'(i >= 2), 32'h500 + 32'(i), 32'h5000);
      if (inst_D == 32'h1234_5678) leak_seen++;
    end
    check("flush_no_leak", 64'(leak_seen), 64'd0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 63) != 0),
          1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 19) == 0),
          1'($urandom_range(0, 2) != 0),
          $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling buffer between the fetch stage and the decode stage of the pipelined CPU.
- Fetch pushes {inst_F, pc_plus4_F} pairs; decode pops them as inst_D and pc_plus4_D.
- Valid/ready handshakes on both sides, so a decode stall no longer freezes the PC register directly.
- A flush input discards all queued instructions when a branch resolves taken in M.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- N, 32, width of the instruction and PC+4 fields.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  fetch offers an entry this cycle.
- in_ready  output  1  queue accepts an entry; equals !full.
- inst_F  input  N  instruction word from fetch.
- pc_plus4_F  input  N  PC+4 of that instruction.
- flush  input  1  discard all entries (taken branch / redirect).
- out_valid  output  1  head entry is presented; equals !empty.
- out_ready  input  1  decode consumes the head entry.
- inst_D  output  N  head instruction; 0 when empty.
- pc_plus4_D  output  N  head PC+4; 0 when empty.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage and pointers:
  - Circular buffer of DEPTH entries, each {inst, pc_plus4}.
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide; index uses the low bits.
  - Wrap is natural modulo 2*DEPTH.
  - full when the pointers differ only in the MSB; empty when they are equal.
  - count = wr_ptr - rd_ptr, truncated to the port width.
- Handshakes:
  - push = in_valid && in_ready; pop = out_valid && out_ready.
  - in_ready and out_valid are combinational from registered pointers only. No dependence on in_valid or out_ready, so there are no combinational loops.
- Latency:
  - An entry pushed at edge k is visible on out_valid/inst_D after edge k; no same-cycle bypass.
  - Minimum fetch-to-decode latency is 1 cycle.
- Ordering: strict FIFO; entries are never reordered or duplicated.
- Simultaneous push and pop:
  - When neither full nor empty, both occur and count is unchanged.
  - When full, in_ready=0, so only the pop happens. The freed slot becomes available next cycle.
  - When empty, out_valid=0, so only the push happens.
- Flush:
  - At the next edge: wr_ptr=rd_ptr=0, count=0, out_valid=0.
  - A push or pop in the flush cycle is ignored; a push accompanying flush is dropped.
  - Storage contents are not cleared; they are masked by empty.
- Reset (reset==0 at an edge):
  - Pointers become 0, so count=0, out_valid=0, in_ready=1, inst_D=0, pc_plus4_D=0.
  - Reset takes priority over flush, push and pop.
  - Reset mid-operation discards all entries.
- Empty output: inst_D and pc_plus4_D are forced to 0 (NOP) while empty, so decode never sees stale data.
- Illegal use: out_ready while empty, or in_valid while full, is ignored with no state change.

Optional Feature:
- Macro: FETCH_QUEUE_STATS_EN.
- Defined: adds outputs stall_cycles (32-bit) and flushed_entries (32-bit).
  - stall_cycles increments every cycle with in_valid && !in_ready.
  - flushed_entries adds count on every flush cycle, plus 1 if a push was attempted in that cycle.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and counters do not exist; functional behaviour is identical.

Test Plan:
- Reset then idle: hold reset=0 two cycles with in_valid=1 → count=0, out_valid=0, in_ready=1, inst_D=0 after release.
- Fill and drain: push 0x00000013, 0x00400093, 0x00800113, 0x00C00193 with pc_plus4 0x4,0x8,0xC,0x10 and out_ready=0.
  - After 4 edges: count=4, in_ready=0.
  - A 5th offer 0xDEADBEEF is not accepted.
  - Then out_ready=1 pops the four words in order; out_valid falls after the 4th pop.
- Concurrent traffic: with count=2, hold in_valid=1 and out_ready=1 for 10 cycles with incrementing words → count stays 2; outputs are the inputs delayed by exactly 2 entries; pointers wrap twice without loss.
- Full plus pop: at count=4, assert in_valid=1 and out_ready=1 → count=3 next cycle and in_ready=1; the following push restores count=4.
- Flush with push: at count=3, assert flush=1 with in_valid=1 and inst_F=0x12345678 → next cycle count=0, out_valid=0; 0x12345678 never appears on inst_D.
  - With FETCH_QUEUE_STATS_EN defined: flushed_entries=4.
- Stall counting (FETCH_QUEUE_STATS_EN defined): hold the queue full with in_valid=1 for 7 cycles → stall_cycles=7; a flush does not change stall_cycles.
